// File: rtl/byte_lane_packer_pkg.sv
// Shared types and helpers for the byte-to-128-bit-word packer.
package packer_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 16;
    localparam int CNT_W      = 5;

    typedef logic [BYTE_W-1:0]            byte_t;
    typedef logic [WORD_BYTES*BYTE_W-1:0] word_t;

    // Lanes at index >= cnt are overwritten with the pad byte.
    function automatic word_t pad_merge(word_t asm_w, int cnt, byte_t pad = '0);
        word_t w;
        w = asm_w;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (k >= cnt) w[k*BYTE_W +: BYTE_W] = pad;
        end
        return w;
    endfunction

endpackage

// File: rtl/byte_lane_packer_if.sv
// Byte-stream input and word-stream output bundle of the packer.
// out_parity exists only when PACKER_BYTE_PARITY_EN is defined.
interface byte_lane_packer_if;
    import packer_pkg::*;

    logic             in_valid;
    logic             in_ready;
    byte_t            in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    word_t            out_data;
    logic [CNT_W-1:0] out_count;
`ifdef PACKER_BYTE_PARITY_EN
    logic [WORD_BYTES-1:0] out_parity;
`endif

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
`ifdef PACKER_BYTE_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
`ifdef PACKER_BYTE_PARITY_EN
        , output out_parity
`endif
    );

endinterface

// File: rtl/byte_lane_packer_out_slot.sv
// Output holding register: captures one packed word (plus parity when PACKER_BYTE_PARITY_EN).
// Latency: word visible the cycle after load.
// Backpressure: word held stable until out_ready; load may coincide with the draining transfer.
module packer_out_slot
    import packer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  word_t            load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output word_t            out_data,
    output logic [CNT_W-1:0] out_count
`ifdef PACKER_BYTE_PARITY_EN
    , output logic [WORD_BYTES-1:0] out_parity
`endif
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PACKER_BYTE_PARITY_EN
    logic [WORD_BYTES-1:0] par_next;

    always_comb begin
        par_next = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            par_next[k] = ^load_data[k*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       out_parity <= '0;
        else if (load) out_parity <= par_next;
    end
`endif

endmodule

// File: rtl/byte_lane_packer.sv
// Packs a byte stream into 16-byte words, byte 0 at [7:0]; in_last closes a word early, PAD_BYTE fills the rest.
// Latency: word valid 1 cycle after its completing accept; 1 byte/cycle sustained.
// Backpressure: one held word plus one pending word; in_ready drops only while a word is pending.
module byte_lane_packer
    import packer_pkg::*;
#(
    parameter int    BYTES_PER_WORD = 16,
    parameter byte_t PAD_BYTE       = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    byte_lane_packer_if.slave bus
);

    localparam logic [3:0] LAST_LANE = 4'(BYTES_PER_WORD - 1);

    logic [119:0]     asm_data;
    byte_t            asm_top;   // lane 15, only needed while a full word is pending
    logic [3:0]       asm_cnt;
    logic             pend;

    logic             slot_free;
    logic             accept;
    logic             complete;
    logic             load;
    word_t            merged;
    word_t            load_word;
    logic [CNT_W-1:0] load_count;

    assign slot_free  = !bus.out_valid || bus.out_ready;
    assign accept     = bus.in_valid && !pend;
    assign complete   = accept && ((asm_cnt == LAST_LANE) || bus.in_last);
    assign load       = slot_free && (pend || complete);
    assign bus.in_ready = !pend;

    // A pending word already holds its final byte; otherwise splice in the byte arriving now.
    always_comb begin
        merged = {asm_top, asm_data};
        if (!pend) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (asm_cnt == 4'(k)) merged[k*BYTE_W +: BYTE_W] = bus.in_data;
            end
        end
    end

    assign load_word  = pad_merge(merged, int'(asm_cnt) + 1, PAD_BYTE);
    assign load_count = CNT_W'(asm_cnt) + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_data <= '0;
            asm_top  <= '0;
            asm_cnt  <= '0;
            pend     <= 1'b0;
        end else if (pend) begin
            if (slot_free) begin
                pend    <= 1'b0;
                asm_cnt <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < WORD_BYTES - 1; k++) begin
                if (asm_cnt == 4'(k)) asm_data[k*BYTE_W +: BYTE_W] <= bus.in_data;
            end
            if (asm_cnt == LAST_LANE) asm_top <= bus.in_data;
            if (complete) begin
                if (slot_free) asm_cnt <= '0;
                else           pend    <= 1'b1;
            end else begin
                asm_cnt <= asm_cnt + 4'd1;
            end
        end
    end

    packer_out_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_word),
        .load_count (load_count),
        .out_ready  (bus.out_ready),
        .out_valid  (bus.out_valid),
        .out_data   (bus.out_data),
        .out_count  (bus.out_count)
`ifdef PACKER_BYTE_PARITY_EN
        , .out_parity (bus.out_parity)
`endif
    );

endmodule

// File: tb/tb_byte_lane_packer.sv
// Directed and random checks of byte_lane_packer against a word-queue reference model.
module tb_byte_lane_packer;
    import packer_pkg::*;

    typedef struct {
        word_t      data;
        logic [4:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_lane_packer_if bus();

    byte_lane_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t  exp_q[$];   // words completed by the stream but not yet taken by the consumer
    byte_t cur[$];     // bytes of the word being gathered
    int    n_checks, n_pass, n_fail;
    int    n_acc, n_xfer, n_rdy_low;
    logic  last_acc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t mkword(input byte_t start);
        word_t w;
        for (int k = 0; k < 16; k++) w[8*k +: 8] = start + 8'(k);
        return w;
    endfunction

    function automatic logic [15:0] par(input word_t w);
        logic [15:0] p;
        for (int k = 0; k < 16; k++) p[k] = ^w[8*k +: 8];
        return p;
    endfunction

    function automatic exp_t close_word();
        exp_t e;
        e.data = '0;
        for (int k = 0; k < cur.size(); k++) e.data[8*k +: 8] = cur[k];
        e.cnt = 5'(cur.size());
        return e;
    endfunction

    // One clock cycle: drive inputs, compare outputs against the model, update the model.
    // The packer can hold at most two finished words (slot + pending), so in_ready is
    // low exactly when two are outstanding, and out_valid is high whenever one is.
    task automatic cyc(input logic v, input byte_t d, input logic l, input logic r, input logic rs);
        logic acc, xf;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
        rst           = rs;
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        chk("in_ready", bus.in_ready, exp_q.size() < 2);
        if (bus.out_valid && exp_q.size() != 0) begin
            chk("out_data", bus.out_data, exp_q[0].data);
            chk("out_count", bus.out_count, exp_q[0].cnt);
`ifdef PACKER_BYTE_PARITY_EN
            chk("out_parity", bus.out_parity, par(exp_q[0].data));
`endif
        end
        if (!bus.in_ready) n_rdy_low++;
        acc      = v && bus.in_ready;
        xf       = bus.out_valid && r;
        last_acc = acc && !rs;
        if (rs) begin
            cur.delete();
            exp_q.delete();
        end else begin
            if (xf) begin
                void'(exp_q.pop_front());
                n_xfer++;
            end
            if (acc) begin
                n_acc++;
                cur.push_back(d);
                if (cur.size() == 16 || l) begin
                    exp_q.push_back(close_word());
                    cur.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int    acc0, x0, low0, nxt;
        word_t w;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_count", bus.out_count, 0);
        chk("rst_out_data", bus.out_data, 0);

        // Full word, no backpressure
        low0 = n_rdy_low;
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
        chk("full_valid", bus.out_valid, 1);
        chk("full_data", bus.out_data, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("full_count", bus.out_count, 16);
        chk("full_ready_drops", n_rdy_low - low0, 0);

        // Partial flush
        cyc(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
        w = '0;
        w[23:0] = 24'hCCBBAA;
        chk("partial_valid", bus.out_valid, 1);
        chk("partial_data", bus.out_data, w);
        chk("partial_count", bus.out_count, 3);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure: 40 offered, 32 fit
        acc0 = n_acc;
        nxt  = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(nxt), 1'b0, 1'b0, 1'b0);
            if (last_acc) nxt++;
        end
        chk("bp_accepted", n_acc - acc0, 32);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_held_data", bus.out_data, mkword(8'h00));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("bp_reload_valid", bus.out_valid, 1);
        chk("bp_reload_ready", bus.in_ready, 1);
        chk("bp_reload_data", bus.out_data, mkword(8'h10));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Slot drains in the same cycle the next word completes
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h3F, 1'b0, 1'b1, 1'b0);
        chk("swap_valid", bus.out_valid, 1);
        chk("swap_in_ready", bus.in_ready, 1);
        chk("swap_data", bus.out_data, mkword(8'h30));
        chk("swap_count", bus.out_count, 16);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset mid-word discards the partial word
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("mid_rst_valid", bus.out_valid, 0);
        x0 = n_xfer;
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b1, 1'b0);
        chk("mid_rst_data", bus.out_data, mkword(8'h10));
        chk("mid_rst_count", bus.out_count, 16);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("mid_rst_words", n_xfer - x0, 1);

`ifdef PACKER_BYTE_PARITY_EN
        cyc(1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
        chk("parity_bits", bus.out_parity, 16'h0001);
        chk("parity_count", bus.out_count, 2);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
`endif

        // Random traffic against the word-queue model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) < 6, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
            if (last_acc) break;
        end
        repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("final_out_valid", bus.out_valid, 0);
        chk("final_in_ready", bus.in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
